// File: rtl/zbuf_arb_pkg.sv
// Shared types and constants for the z-buffer port arbiter.
package zbuf_arb_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned CNT_W     = 16;

  typedef logic [IDX_W-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Round-robin successor of a port index, wrapping 3 -> 0.
  function automatic port_idx_t next_idx(input port_idx_t i);
    return port_idx_t'(i + port_idx_t'(1));
  endfunction

endpackage

// File: rtl/zbuf_port_arbiter_if.sv
// FIFO-side and z-buffer-side signals of the arbiter, bundled as one interface.
interface zbuf_port_arbiter_if #(
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned MEM_LENGTH  = 8
);
  import zbuf_arb_pkg::*;

  logic                   req_1, req_2, req_3, req_4;
  logic [MEM_LENGTH-1:0]  fill_1, fill_2, fill_3, fill_4;
  logic [PIXEL_WIDTH-1:0] pix_in_1, pix_in_2, pix_in_3, pix_in_4;
  logic                   pop_1, pop_2, pop_3, pop_4;
  logic [PIXEL_WIDTH-1:0] pix_out;
  logic                   send_z_buffer;
  logic                   rdy_z_buffer;
  port_idx_t              grant_id;

  modport master (
    input  req_1, req_2, req_3, req_4,
    input  fill_1, fill_2, fill_3, fill_4,
    input  pix_in_1, pix_in_2, pix_in_3, pix_in_4,
    input  rdy_z_buffer,
    output pop_1, pop_2, pop_3, pop_4,
    output pix_out, send_z_buffer, grant_id
  );

  modport slave (
    output req_1, req_2, req_3, req_4,
    output fill_1, fill_2, fill_3, fill_4,
    output pix_in_1, pix_in_2, pix_in_3, pix_in_4,
    output rdy_z_buffer,
    input  pop_1, pop_2, pop_3, pop_4,
    input  pix_out, send_z_buffer, grant_id
  );

endinterface

// File: rtl/zbuf_port_arbiter_rr_pick.sv
// Combinational winner select: fullest urgent FIFO first, else first requester
// in round-robin order from ptr_i; equal fills resolve in round-robin order.
module zbuf_rr_pick
  import zbuf_arb_pkg::*;
#(
  parameter int unsigned MEM_LENGTH = 8
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [NUM_PORTS-1:0]  urgent_i,
  input  logic [MEM_LENGTH-1:0] fill_i [NUM_PORTS],
  input  port_idx_t             ptr_i,
  output logic                  any_o,
  output port_idx_t             winner_o
);

  port_idx_t             idx;
  port_idx_t             win_u, win_r;
  logic                  found_u, found_r;
  logic [MEM_LENGTH-1:0] best_fill;

  // Strict '>' keeps the earliest candidate in rr order on equal fill.
  always_comb begin
    idx       = ptr_i;
    win_u     = '0;
    win_r     = '0;
    found_u   = 1'b0;
    found_r   = 1'b0;
    best_fill = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = port_idx_t'(ptr_i + port_idx_t'(k));
      if (urgent_i[idx] && (!found_u || (fill_i[idx] > best_fill))) begin
        found_u   = 1'b1;
        win_u     = idx;
        best_fill = fill_i[idx];
      end
      if (req_i[idx] && !found_r) begin
        found_r = 1'b1;
        win_r   = idx;
      end
    end
    any_o    = |req_i;
    winner_o = found_u ? win_u : win_r;
  end

endmodule

// File: rtl/zbuf_port_arbiter.sv
// Shares the z-buffer write port among four pixel FIFOs with a one-entry output stage.
// Optional per-FIFO grant counters are built when ZBUF_ARB_STATS_EN is defined.
module zbuf_port_arbiter
  import zbuf_arb_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 16,
  parameter int unsigned MEM_LENGTH    = 8,
  parameter int unsigned URGENT_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  zbuf_port_arbiter_if.master  zb
`ifdef ZBUF_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]     grant_cnt_1,
  output logic [CNT_W-1:0]     grant_cnt_2,
  output logic [CNT_W-1:0]     grant_cnt_3,
  output logic [CNT_W-1:0]     grant_cnt_4
`endif
);

  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   urgent;
  logic [MEM_LENGTH-1:0]  fill   [NUM_PORTS];
  logic [PIXEL_WIDTH-1:0] pix_in [NUM_PORTS];
  logic                   any;
  port_idx_t              winner;

  arb_state_t             state_q, state_d;
  port_idx_t              ptr_q, ptr_d;
  port_idx_t              gid_q, gid_d;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                   send_q, send_d;
  logic                   do_pop_c;
  logic [NUM_PORTS-1:0]   pop_c;

  assign req       = {zb.req_4, zb.req_3, zb.req_2, zb.req_1};
  assign fill[0]   = zb.fill_1;
  assign fill[1]   = zb.fill_2;
  assign fill[2]   = zb.fill_3;
  assign fill[3]   = zb.fill_4;
  assign pix_in[0] = zb.pix_in_1;
  assign pix_in[1] = zb.pix_in_2;
  assign pix_in[2] = zb.pix_in_3;
  assign pix_in[3] = zb.pix_in_4;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      urgent[i] = req[i] && (fill[i] >= MEM_LENGTH'(URGENT_THRESH));
    end
  end

  zbuf_rr_pick #(
    .MEM_LENGTH (MEM_LENGTH)
  ) u_pick (
    .req_i    (req),
    .urgent_i (urgent),
    .fill_i   (fill),
    .ptr_i    (ptr_q),
    .any_o    (any),
    .winner_o (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      pix_q   <= '0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      pix_q   <= pix_d;
      send_q  <= send_d;
    end
  end

  // A pop refills the stage; in HOLD it is only allowed while the current word drains.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    pix_d    = pix_q;
    send_d   = send_q;
    pop_c    = '0;
    do_pop_c = !reset && any && ((state_q == IDLE) || zb.rdy_z_buffer);
    if (do_pop_c) begin
      pop_c[winner] = 1'b1;
      ptr_d         = next_idx(winner);
      gid_d         = winner;
      pix_d         = pix_in[winner];
      send_d        = 1'b1;
      state_d       = HOLD;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        HOLD: begin
          if (zb.rdy_z_buffer) begin
            send_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign zb.pop_1         = pop_c[0];
  assign zb.pop_2         = pop_c[1];
  assign zb.pop_3         = pop_c[2];
  assign zb.pop_4         = pop_c[3];
  assign zb.pix_out       = pix_q;
  assign zb.send_z_buffer = send_q;
  assign zb.grant_id      = gid_q;

`ifdef ZBUF_ARB_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-FIFO grant counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop_c[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_1 = cnt_q[0];
  assign grant_cnt_2 = cnt_q[1];
  assign grant_cnt_3 = cnt_q[2];
  assign grant_cnt_4 = cnt_q[3];
`endif

endmodule
